axis_rr_packet_arbiter: RTL
===========================

// Module: axis_rr_packet_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter merging NUM_IN AXI-Stream sources (frame_gen_and_check
//  generators, port pipelines) onto one 256-bit nf10 interconnect stream. A grant is held from
//  the first beat to the tlast beat, so packets are never interleaved. The output is registered
//  through a 2-entry skid buffer, so m_axis_tready has no combinational path to any s_axis_tready.
// PARAMETERS
//  NUM_IN      4    number of input streams, 2..8
//  DATA_W      256  tdata width; tkeep width is DATA_W/8
//  TUSER_W     36   packed tuser {out_vport[8],in_vport[3],out_port[8],in_port[3],packet_length[14]}
// PORTS
//  axi_aclk        in   1                  single clock for all logic
//  axi_resetn      in   1                  asynchronous, active-low reset
//  s_axis_tdata    in   NUM_IN*DATA_W      input i occupies slice i
//  s_axis_tkeep    in   NUM_IN*DATA_W/8    per-input byte enables
//  s_axis_tuser    in   NUM_IN*TUSER_W     per-input sideband; forwarded unmodified
//  s_axis_tvalid   in   NUM_IN             per-input valid
//  s_axis_tlast    in   NUM_IN             per-input end of packet
//  s_axis_tready   out  NUM_IN             per-input ready; at most one bit is high
//  m_axis_tdata    out  DATA_W             merged stream data
//  m_axis_tkeep    out  DATA_W/8           merged byte enables
//  m_axis_tuser    out  TUSER_W            merged sideband
//  m_axis_tvalid   out  1                  merged valid
//  m_axis_tlast    out  1                  merged end of packet
//  m_axis_tready   in   1                  downstream ready
//  grant           out  NUM_IN             one-hot owner of the stream; 0 when idle
//  pkt_count       out  32                 packets completed (tlast accepted); wraps at 2^32
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; grant=0, s_axis_tready=0, m_axis_tvalid=0,
//    m_axis_tdata/tkeep/tuser/tlast=0, pkt_count=0, skid empty, last_ptr=NUM_IN-1.
//  - FSM IDLE: if any s_axis_tvalid is high, pick the first valid index searching
//    last_ptr+1, last_ptr+2, ... modulo NUM_IN. Register it into grant and last_ptr; go to LOCK.
//  - FSM LOCK: s_axis_tready[g] = skid not full; all other ready bits are 0. A beat is accepted
//    when valid&ready. Accepting a beat with tlast: grant<=0, pkt_count+=1, go to IDLE.
//  - Timing: 1 bubble cycle per packet (arbitration). tvalid seen in IDLE in cycle 0;
//    first beat is accepted at the end of cycle 1; m_axis_tvalid is high in cycle 2.
//  - tvalid low mid-packet while in LOCK: grant is held, with no timeout; the stall passes downstream.
//  - Skid buffer: 2 entries. s-side ready = (count<2) registered. Full throughput of 1 beat per
//    cycle while m_axis_tready=1. Order is preserved. m_axis_* is stable while tvalid&!tready.
//  - Simultaneous tlast accept and new requests: no grant that cycle; re-arbitrate next cycle
//    from the updated last_ptr. A single active requester gets every other packet slot (no lockout).
//  - Reset mid-packet: the partial packet is discarded and the output clears immediately.
//    Upstream is responsible for resyncing.
//  - tuser, tkeep and tdata pass bit-exact. The block does not check packet_length.
// STRUCTURE
//  - Shared package nf10_axis_pkg: TUSER field offsets/widths, the DATA_W default, and the
//    IDLE/LOCK state localparams.
//  - One sub-module, axis_skid_reg (DATA_W, TUSER_W): the 2-entry output register. The top level
//    holds the FSM, the round-robin pointer, the input mux and pkt_count.
// TESTING
//  1. Reset, single source: in0 sends 3 beats, tdata=1,2,3, last on 3. Expect m_axis 1,2,3 with
//     tlast on 3 at cycles 2..4, grant=0001, then pkt_count=1.
//  2. All 4 inputs continuously valid, 1-beat packets. Expect grant order 0,1,2,3,0 and
//     a m_axis_tvalid duty of 1 beat every 2 cycles.
//  3. in1 sends a 4-beat packet; in2 raises valid at beat 2. Expect no interleave: all of in1's
//     beats, then in2's beats, with s_axis_tready[2]=0 until in1's tlast is accepted.
//  4. Backpressure: m_axis_tready toggles 1,0,0,1 during an 8-beat packet (tdata=0xAFFEDEAD+i).
//     Expect no loss or duplication, m_axis held stable while stalled, and s_axis_tready low
//     once the skid is full.
//  5. Assert axi_resetn low at beat 3 of 6, then release. Expect outputs 0 asynchronously,
//     pkt_count=0, and the first post-reset grant to in0 when all are valid.
//  6. Preload pkt_count to 0xFFFFFFFF by forcing it, then send 1 packet. Expect pkt_count=0.

Source files
------------

// File: rtl/nf10_axis_pkg.sv
// rtl/nf10_axis_pkg.sv - nf10 stream constants: tuser field layout, default widths, arbiter states
package nf10_axis_pkg;

  localparam int DATA_W_DEF = 256;

  localparam int TUSER_LEN_LSB       = 0;
  localparam int TUSER_LEN_W         = 14;
  localparam int TUSER_IN_PORT_LSB   = TUSER_LEN_LSB + TUSER_LEN_W;
  localparam int TUSER_IN_PORT_W     = 3;
  localparam int TUSER_OUT_PORT_LSB  = TUSER_IN_PORT_LSB + TUSER_IN_PORT_W;
  localparam int TUSER_OUT_PORT_W    = 8;
  localparam int TUSER_IN_VPORT_LSB  = TUSER_OUT_PORT_LSB + TUSER_OUT_PORT_W;
  localparam int TUSER_IN_VPORT_W    = 3;
  localparam int TUSER_OUT_VPORT_LSB = TUSER_IN_VPORT_LSB + TUSER_IN_VPORT_W;
  localparam int TUSER_OUT_VPORT_W   = 8;
  localparam int TUSER_W_DEF         = TUSER_OUT_VPORT_LSB + TUSER_OUT_VPORT_W;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

endpackage

// File: rtl/axis_skid_reg.sv
// rtl/axis_skid_reg.sv - 2-entry registered output stage; input ready depends only on occupancy
module axis_skid_reg #(
  parameter int DATA_W  = 256,
  parameter int TUSER_W = 36
) (
  input  logic                  axi_aclk,
  input  logic                  axi_resetn,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic [DATA_W/8-1:0]   s_tkeep,
  input  logic [TUSER_W-1:0]    s_tuser,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_W-1:0]     m_tdata,
  output logic [DATA_W/8-1:0]   m_tkeep,
  output logic [TUSER_W-1:0]    m_tuser,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  localparam int BEAT_W = DATA_W + DATA_W / 8 + TUSER_W + 1;

  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] head_q;
  logic [BEAT_W-1:0] tail_q;
  logic [1:0]        count_q;
  logic              push;
  logic              pop;

  assign in_beat  = {s_tdata, s_tkeep, s_tuser, s_tlast};
  assign s_tready = (count_q != 2'd2);
  assign m_tvalid = (count_q != 2'd0);
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;
  assign {m_tdata, m_tkeep, m_tuser, m_tlast} = head_q;

  // head_q only moves on a pop (or when empty), so the output holds during a stall
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_q  <= in_beat;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= in_beat;
          end else if (push) begin
            tail_q  <= in_beat;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_q  <= tail_q;
            count_q <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// rtl/axis_rr_packet_arbiter.sv - packet-granular round-robin merge of NUM_IN streams
module axis_rr_packet_arbiter
  import nf10_axis_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TUSER_W = TUSER_W_DEF
) (
  input  logic                          axi_aclk,
  input  logic                          axi_resetn,
  input  logic [NUM_IN*DATA_W-1:0]      s_axis_tdata,
  input  logic [NUM_IN*DATA_W/8-1:0]    s_axis_tkeep,
  input  logic [NUM_IN*TUSER_W-1:0]     s_axis_tuser,
  input  logic [NUM_IN-1:0]             s_axis_tvalid,
  input  logic [NUM_IN-1:0]             s_axis_tlast,
  output logic [NUM_IN-1:0]             s_axis_tready,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic [DATA_W/8-1:0]           m_axis_tkeep,
  output logic [TUSER_W-1:0]            m_axis_tuser,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [NUM_IN-1:0]             grant,
  output logic [31:0]                   pkt_count
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(NUM_IN);

  logic              state_q;
  logic              state_d;
  logic [NUM_IN-1:0] grant_q;
  logic [PTR_W-1:0]  last_ptr_q;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [31:0]       cnt_q;

  logic [DATA_W-1:0]  mux_tdata;
  logic [KEEP_W-1:0]  mux_tkeep;
  logic [TUSER_W-1:0] mux_tuser;
  logic               mux_tlast;
  logic               mux_tvalid;
  logic               skid_in_valid;
  logic               skid_tready;
  logic               beat_acc;
  logic               last_acc;

  // Lowest rotation offset wins: scan downwards so the nearest requester overwrites last
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      if (s_axis_tvalid[(int'(last_ptr_q) + k) % NUM_IN]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'((int'(last_ptr_q) + k) % NUM_IN);
      end
    end
  end

  always_comb begin
    mux_tdata  = '0;
    mux_tkeep  = '0;
    mux_tuser  = '0;
    mux_tlast  = 1'b0;
    mux_tvalid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_q[i]) begin
        mux_tdata  = s_axis_tdata[i*DATA_W +: DATA_W];
        mux_tkeep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
        mux_tuser  = s_axis_tuser[i*TUSER_W +: TUSER_W];
        mux_tlast  = s_axis_tlast[i];
        mux_tvalid = s_axis_tvalid[i];
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_LOCK;
      default: if (last_acc) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    skid_in_valid = 1'b0;
    if (state_q == ST_LOCK) begin
      s_axis_tready = skid_tready ? grant_q : '0;
      skid_in_valid = mux_tvalid;
    end
  end

  assign beat_acc = skid_in_valid & skid_tready;
  assign last_acc = beat_acc & mux_tlast;

  // Grant drops on the tlast edge, forcing one idle arbitration cycle between packets
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      grant_q    <= '0;
      last_ptr_q <= PTR_W'(NUM_IN - 1);
      cnt_q      <= '0;
    end else begin
      if (state_q == ST_IDLE && pick_valid) begin
        grant_q    <= NUM_IN'(1) << pick_idx;
        last_ptr_q <= pick_idx;
      end else if (last_acc) begin
        grant_q <= '0;
      end
      if (last_acc) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign grant     = grant_q;
  assign pkt_count = cnt_q;

  axis_skid_reg #(
    .DATA_W  (DATA_W),
    .TUSER_W (TUSER_W)
  ) u_skid (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .s_tdata    (mux_tdata),
    .s_tkeep    (mux_tkeep),
    .s_tuser    (mux_tuser),
    .s_tlast    (mux_tlast),
    .s_tvalid   (skid_in_valid),
    .s_tready   (skid_tready),
    .m_tdata    (m_axis_tdata),
    .m_tkeep    (m_axis_tkeep),
    .m_tuser    (m_axis_tuser),
    .m_tlast    (m_axis_tlast),
    .m_tvalid   (m_axis_tvalid),
    .m_tready   (m_axis_tready)
  );

endmodule
